// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
//   Conditions a raw inductive-loop detector into a clean presence level,
//   a latched side-street service request and a saturating arrival count.
//
// Parameters
//   DEBOUNCE_CYCLES  synchronized samples needed to flip vehicle_present (2..255)
//   MIN_PRESENCE     debounced-present cycles needed to raise a request (2..65535)
//   COUNT_WIDTH      width of vehicle_count
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous, active-high reset
//   loop_raw         asynchronous, bouncy loop-detector input (1 = metal)
//   sensor_ack       controller pulse accepting the pending request
//   count_clear      synchronous clear of vehicle_count
//   traffic_sensor   latched service request (registered)
//   vehicle_present  debounced presence level
//   vehicle_count    saturating count of 0->1 presence transitions
module traffic_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MIN_PRESENCE    = 64,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   loop_raw,
  input  logic                   sensor_ack,
  input  logic                   count_clear,
  output logic                   traffic_sensor,
  output logic                   vehicle_present,
  output logic [COUNT_WIDTH-1:0] vehicle_count
);

  // Elaboration-time parameter range checks.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 2..255");
  end
  if (MIN_PRESENCE < 2 || MIN_PRESENCE > 65535) begin : g_bad_presence
    $error("MIN_PRESENCE out of range 2..65535");
  end
  if (COUNT_WIDTH < 1) begin : g_bad_width
    $error("COUNT_WIDTH must be at least 1");
  end

  localparam logic [7:0]  DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] PRES_LIMIT = 16'(MIN_PRESENCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUALIFY,
    S_REQUEST,
    S_WAIT_CLEAR
  } state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer: the only consumer of loop_raw.
  // ---------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= loop_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer
  // ---------------------------------------------------------------------
  logic [7:0] db_cnt_q;
  logic [7:0] db_cnt_d;
  logic       present_q;
  logic       present_d;
  logic       present_rise;

  // The counter climbs while the synchronized sample disagrees with the
  // debounced level and is cleared on any agreeing sample. The level flips
  // on the edge after the counter holds DEBOUNCE_CYCLES, which together with
  // the two synchronizer stages places the change DEBOUNCE_CYCLES+2 edges
  // after loop_raw is first sampled.
  always_comb begin
    present_d = present_q;
    db_cnt_d  = '0;
    if (sync2_q != present_q) begin
      if (db_cnt_q == DB_LIMIT) begin
        present_d = ~present_q;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  assign present_rise = ~present_q & present_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q  <= '0;
      present_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      present_q <= present_d;
    end
  end

  // ---------------------------------------------------------------------
  // Request FSM with saturating presence counter
  // ---------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [15:0] pres_q;
  logic [15:0] pres_d;
  logic [15:0] pres_inc;
  logic        sensor_q;

  assign pres_inc = (pres_q == '1) ? pres_q : pres_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pres_d  = pres_q;
    unique case (state_q)
      S_IDLE: begin
        if (present_q) begin
          state_d = S_QUALIFY;
          pres_d  = 16'd1;
        end
      end
      S_QUALIFY: begin
        if (!present_q) begin
          state_d = S_IDLE;
          pres_d  = '0;
        end else begin
          pres_d = pres_inc;
          // Promote on the edge the count reaches the threshold.
          if (pres_inc == PRES_LIMIT) begin
            state_d = S_REQUEST;
          end
        end
      end
      S_REQUEST: begin
        // Request stays latched regardless of presence until acknowledged.
        if (sensor_ack) begin
          state_d = S_WAIT_CLEAR;
        end
      end
      S_WAIT_CLEAR: begin
        // No re-request until the loop has emptied.
        if (!present_q) begin
          state_d = S_IDLE;
          pres_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pres_d  = '0;
      end
    endcase
  end

  // traffic_sensor is registered from the next state so it is high exactly
  // while state_q is S_REQUEST, with no combinational path from inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pres_q   <= '0;
      sensor_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pres_q   <= pres_d;
      sensor_q <= (state_d == S_REQUEST);
    end
  end

  // ---------------------------------------------------------------------
  // Arrival counter: clear wins over a coincident increment.
  // ---------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] vcount_q;
  logic [COUNT_WIDTH-1:0] vcount_d;

  always_comb begin
    vcount_d = vcount_q;
    if (count_clear) begin
      vcount_d = '0;
    end else if (present_rise && (vcount_q != '1)) begin
      vcount_d = vcount_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vcount_q <= '0;
    end else begin
      vcount_q <= vcount_d;
    end
  end

  assign traffic_sensor  = sensor_q;
  assign vehicle_present = present_q;
  assign vehicle_count   = vcount_q;

endmodule
